// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment constants are active-high (bit0=a .. bit6=g); the consumer applies output polarity.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;
  localparam logic [6:0] SEG_TWO   = 7'h5B;

  localparam logic [2:0] EDIT_NONE  = 3'd0;
  localparam logic [2:0] EDIT_SEC   = 3'd1;
  localparam logic [2:0] EDIT_MIN   = 3'd2;
  localparam logic [2:0] EDIT_HOUR  = 3'd3;
  localparam logic [2:0] EDIT_DAY   = 3'd4;
  localparam logic [2:0] EDIT_MONTH = 3'd5;
  localparam logic [2:0] EDIT_YEAR  = 3'd6;

  localparam logic TIME_PAGE = 1'b0;
  localparam logic DATE_PAGE = 1'b1;

  function automatic logic [6:0] seg_pol(input logic [6:0] s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..DIV-1 counter with a one-cycle tick while at DIV-1.
// Latency: tick asserted combinationally from the count; no backpressure.
module tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            W    = $clog2(DIV);
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// 8-digit seven-segment scan driver with time/date pages and edit-field blinking.
// Latency: an/seg registered together one cycle after scan_tick; no backpressure.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [13:0] sec_7seg,
  input  logic [13:0] min_7seg,
  input  logic [13:0] hour_7seg,
  input  logic [13:0] day_7seg,
  input  logic [13:0] month_7seg,
  input  logic [27:0] year_7seg,
  input  logic        page_btn,
  input  logic [2:0]  edit_field,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        page
);

  localparam int DIV       = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / 4;

  localparam logic [6:0] OUT_BLANK = seg_pol(SEG_BLANK, SEG_ACTIVE_LOW);
  localparam logic [6:0] OUT_DASH  = seg_pol(SEG_DASH,  SEG_ACTIVE_LOW);
  localparam logic [6:0] OUT_ZERO  = seg_pol(SEG_ZERO,  SEG_ACTIVE_LOW);
  localparam logic [6:0] OUT_TWO   = seg_pol(SEG_TWO,   SEG_ACTIVE_LOW);

  logic       scan_tick, blink_tick;
  logic [2:0] d_q, d_d;
  logic       blink_on_q, blink_on_d;
  logic       page_q, page_d;
  logic       btn_q, btn_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [6:0] dig_seg;
  logic [2:0] dig_field;
  logic       blank_dig;
  logic       unused_year_hi;

  assign unused_year_hi = ^year_7seg[27:14];

  tick_gen #(.DIV(DIV)) u_scan_tick (
    .clk   (clk_100MHz),
    .rst_n (reset),
    .tick  (scan_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk   (clk_100MHz),
    .rst_n (reset),
    .tick  (blink_tick)
  );

  // Forced page from edit_field wins over a coincident button edge.
  always_comb begin
    btn_d      = page_btn;
    blink_on_d = blink_tick ? ~blink_on_q : blink_on_q;
    d_d        = scan_tick ? d_q + 3'd1 : d_q;
    case (edit_field)
      EDIT_SEC, EDIT_MIN, EDIT_HOUR:   page_d = TIME_PAGE;
      EDIT_DAY, EDIT_MONTH, EDIT_YEAR: page_d = DATE_PAGE;
      default:                         page_d = (page_btn && !btn_q) ? ~page_q : page_q;
    endcase
  end

  // The mux looks at next-state digit and page so the registered pair is always current.
  always_comb begin
    dig_seg   = OUT_BLANK;
    dig_field = EDIT_NONE;
    if (page_d == TIME_PAGE) begin
      case (d_d)
        3'd7:    begin dig_seg = hour_7seg[13:7]; dig_field = EDIT_HOUR; end
        3'd6:    begin dig_seg = hour_7seg[6:0];  dig_field = EDIT_HOUR; end
        3'd5:    dig_seg = OUT_DASH;
        3'd4:    begin dig_seg = min_7seg[13:7];  dig_field = EDIT_MIN;  end
        3'd3:    begin dig_seg = min_7seg[6:0];   dig_field = EDIT_MIN;  end
        3'd2:    dig_seg = OUT_DASH;
        3'd1:    begin dig_seg = sec_7seg[13:7];  dig_field = EDIT_SEC;  end
        default: begin dig_seg = sec_7seg[6:0];   dig_field = EDIT_SEC;  end
      endcase
    end else begin
      case (d_d)
        3'd7:    begin dig_seg = day_7seg[13:7];   dig_field = EDIT_DAY;   end
        3'd6:    begin dig_seg = day_7seg[6:0];    dig_field = EDIT_DAY;   end
        3'd5:    begin dig_seg = month_7seg[13:7]; dig_field = EDIT_MONTH; end
        3'd4:    begin dig_seg = month_7seg[6:0];  dig_field = EDIT_MONTH; end
        3'd3:    dig_seg = OUT_TWO;
        3'd2:    dig_seg = OUT_ZERO;
        3'd1:    begin dig_seg = year_7seg[13:7];  dig_field = EDIT_YEAR;  end
        default: begin dig_seg = year_7seg[6:0];   dig_field = EDIT_YEAR;  end
      endcase
    end
    blank_dig = !blink_on_q && (dig_field != EDIT_NONE) && (dig_field == edit_field);
    an_d      = scan_tick ? ~(8'd1 << d_d) : an_q;
    seg_d     = scan_tick ? (blank_dig ? OUT_BLANK : dig_seg) : seg_q;
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      d_q        <= 3'd0;
      blink_on_q <= 1'b1;
      page_q     <= TIME_PAGE;
      btn_q      <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= OUT_BLANK;
    end else begin
      d_q        <= d_d;
      blink_on_q <= blink_on_d;
      page_q     <= page_d;
      btn_q      <= btn_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign page = page_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: stimulus queues expected digits, a monitor checks each an step.
module tb_seg7_scan_mux;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic [13:0] sec_7seg, min_7seg, hour_7seg, day_7seg, month_7seg;
  logic [27:0] year_7seg;
  logic        page_btn;
  logic [2:0]  edit_field;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        page;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  int         nchk = 0;
  int         npass = 0;
  int         cyc = 0;
  logic [6:0] time_tab [8];
  logic [6:0] date_tab [8];

  seg7_scan_mux #(.CLK_HZ(1600), .SCAN_HZ(100), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .sec_7seg   (sec_7seg),
    .min_7seg   (min_7seg),
    .hour_7seg  (hour_7seg),
    .day_7seg   (day_7seg),
    .month_7seg (month_7seg),
    .year_7seg  (year_7seg),
    .page_btn   (page_btn),
    .edit_field (edit_field),
    .an         (an),
    .seg        (seg),
    .page       (page)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Active-low glyph for a decimal digit.
  function automatic logic [6:0] enc(input int v);
    logic [6:0] hi;
    case (v)
      0: hi = 7'h3F; 1: hi = 7'h06; 2: hi = 7'h5B; 3: hi = 7'h4F; 4: hi = 7'h66;
      5: hi = 7'h6D; 6: hi = 7'h7D; 7: hi = 7'h07; 8: hi = 7'h7F; default: hi = 7'h6F;
    endcase
    return ~hi;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  // Queue the next n scan steps. Step m lands at posedge 16*m after reset release;
  // blink_on seen at posedge k is on when floor((k-1)/400) is even.
  task automatic push_scan(input int n, input bit date_pg, input logic [7:0] mask);
    exp_t e;
    int   m, dig;
    bit   bon;
    while (cyc % 16 != 8) tick_wait(1);
    for (int k = 1; k <= n; k++) begin
      m     = cyc / 16 + k;
      dig   = m % 8;
      bon   = (((16 * m - 1) / 400) % 2) == 0;
      e.an  = ~(8'd1 << dig);
      e.seg = (mask[dig] && !bon) ? 7'h7F : (date_pg ? date_tab[dig] : time_tab[dig]);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick_wait(1);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every change of an while out of reset is one presented digit.
  initial begin
    logic [7:0] an_prev;
    int         last_cyc;
    exp_t       e;
    an_prev  = 8'hFF;
    last_cyc = 0;
    forever begin
      @(negedge clk_100MHz);
      if (!reset) begin
        an_prev  = an;
        last_cyc = 0;
      end else if (an !== an_prev) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("scan_an", an, e.an);
          check("scan_seg", seg, e.seg);
          check("scan_gap", cyc - last_cyc, 16);
        end
        an_prev  = an;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $display("%0d/%0d checks passed", npass, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    hour_7seg  = {enc(1), enc(2)};
    min_7seg   = {enc(3), enc(4)};
    sec_7seg   = {enc(5), enc(6)};
    day_7seg   = {enc(2), enc(8)};
    month_7seg = {enc(0), enc(9)};
    year_7seg  = {14'h3FFF, enc(2), enc(5)};
    page_btn   = 1'b0;
    edit_field = 3'd0;
    time_tab = '{enc(6), enc(5), 7'h3F, enc(4), enc(3), 7'h3F, enc(2), enc(1)};
    date_tab = '{enc(5), enc(2), 7'h40, 7'h24, enc(9), enc(0), enc(8), enc(2)};

    // Reset and scan order on the time page
    reset = 1'b1;
    #2 reset = 1'b0;
    tick_wait(3);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_page", page, 1'b0);
    reset = 1'b1;
    push_scan(9, 1'b0, 8'h00);
    wait_drain(400);

    // Button edge to date page, held high gives a single toggle
    page_btn = 1'b1;
    tick_wait(1);
    check("btn_page_1cyc", page, 1'b1);
    tick_wait(99);
    check("btn_held_no_retoggle", page, 1'b1);
    page_btn = 1'b0;
    push_scan(8, 1'b1, 8'h00);
    wait_drain(400);

    // Editing minutes forces time page and blinks digits 4/3
    edit_field = 3'd2;
    tick_wait(1);
    check("edit_min_page", page, 1'b0);
    push_scan(56, 1'b0, 8'b0001_1000);
    wait_drain(1200);

    // Editing month forces date page; button edge is ignored while forced
    edit_field = 3'd5;
    tick_wait(2);
    check("edit_month_page", page, 1'b1);
    push_scan(16, 1'b1, 8'b0011_0000);
    wait_drain(600);
    page_btn = 1'b1;
    tick_wait(1);
    check("forced_vs_btn", page, 1'b1);
    tick_wait(2);
    check("forced_hold", page, 1'b1);
    edit_field = 3'd0;
    page_btn   = 1'b0;
    tick_wait(2);
    check("edit_release_hold", page, 1'b1);
    page_btn = 1'b1;
    tick_wait(1);
    check("btn_after_edit", page, 1'b0);
    page_btn = 1'b0;

    // Reset during digit 5 clears outputs at once and restarts the scan
    for (int i = 0; i < 300 && an !== 8'hDF; i++) tick_wait(1);
    check("reach_digit5", an, 8'hDF);
    tick_wait(1);
    reset = 1'b0;
    #1;
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", seg, 7'h7F);
    tick_wait(3);
    reset = 1'b1;
    push_scan(3, 1'b0, 8'h00);
    wait_drain(200);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed 8-digit seven-segment scan driver that sits directly downstream of the clock/calendar top. It consumes the per-field 14-bit segment words and drives one shared 7-bit segment bus plus 8 active-low digit enables. It shows either a time page (HH-MM-SS) or a date page (DD MM 20 YY). It also blinks the field currently being edited.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- SCAN_HZ, 1000: digit scan rate, one digit per scan tick. DIV = CLK_HZ/SCAN_HZ, must be ≥ 2.
- SEG_ACTIVE_LOW, 1: polarity of the segment words, both input and output. 1 means segment lit = 0.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- sec_7seg, min_7seg, hour_7seg, day_7seg, month_7seg  in  14 each  [13:7] is the high digit, [6:0] the low digit. Bit order is bit0=a … bit6=g.
- year_7seg  in  28  only [13:0] is used; [27:14] is ignored.
- page_btn  in  1  debounced level. A rising edge toggles the page.
- edit_field  in  3  0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year, 7 treated as none.
- an  out  8  digit enables, active-low. an[7] is the leftmost digit.
- seg  out  7  segment bus.
- page  out  1  0 = time page, 1 = date page.

## Operation
- Constants, given active-high and inverted when SEG_ACTIVE_LOW=1:
  - BLANK 0x00
  - DASH 0x40
  - ZERO 0x3F
  - TWO 0x5B
- Time page, digits 7..0: hour[13:7], hour[6:0], DASH, min[13:7], min[6:0], DASH, sec[13:7], sec[6:0].
- Date page, digits 7..0: day hi, day lo, month hi, month lo, TWO, ZERO, year[13:7], year[6:0].
- Scan prescaler counts 0..DIV-1 and asserts scan_tick when it reaches DIV-1. On scan_tick, digit index d advances 0→1→…→7→0.
- Blink prescaler counts 0..CLK_HZ/4-1. At wrap, blink_on toggles, giving a 2 Hz blink with 50% duty.
- Page register:
  - A rising edge of page_btn, detected by registering the previous sample, toggles page.
  - When edit_field is 1–3, page is forced to 0 every cycle. When it is 4–6, page is forced to 1. Forcing overrides a simultaneous edge.
  - When edit_field returns to 0, page holds its last value.
- Blinking: the two digits of the selected field are always on the current page. While blink_on=0, those digits output BLANK. an is still driven for them so the scan period stays uniform.
- Input words are sampled combinationally at the registration cycle. No other state is held on them.

## Timing
- Reset values:
  - an = 8'hFF
  - seg = BLANK
  - page = 0
  - d = 0
  - both prescalers = 0
  - blink_on = 1
  - page_btn history = 0
- an and seg are registered. Both update in the cycle after scan_tick, together, so they never show a mismatched digit/segment pair.
- Output after the first scan_tick following reset release: an = ~(1<<1), meaning digit 1 is displayed first. Digit 0 is shown from the 8th tick after that, and so on cyclically.
- Latency:
  - Page change or edit_field change: visible on the next registered digit.
  - page_btn edge to page output: 1 cycle.
- page_btn held high gives exactly one toggle. A toggle and a scan_tick in the same cycle are both honoured.
- A reset asserted mid-scan forces the reset values immediately (asynchronous) and restarts the scan from d = 0.

## Structure
- Shared package seg7_pkg holds:
  - the BLANK, DASH, ZERO and TWO constants in active-high form;
  - the edit_field encodings as named localparams;
  - page encodings TIME_PAGE = 0 and DATE_PAGE = 1.
- Sub-module tick_gen (parameter DIV) is a free-running counter with a one-cycle tick output and asynchronous active-low reset. It is instantiated twice: once for scan, once for blink.
- Everything else stays in seg7_scan_mux: page register, edge detect, digit mux, blink gating, output registers.

## Test plan
All scenarios use CLK_HZ=1600, SCAN_HZ=100 (DIV=16, blink half-period 400 cycles) and SEG_ACTIVE_LOW=1.
- Reset and scan:
  - Stimulus: hold reset low, then release.
  - Required: an = FF and seg = 7F while in reset. After release, an steps FD, FB, …, 7F, FE, FD with exactly 16 cycles per step.
- Time page mapping:
  - Stimulus: drive hour/min/sec words encoding 12:34:56.
  - Required: over one full scan, seg per digit matches the hour/min/sec nibbles, and digits 5 and 2 show ~0x40 = 0x3F.
- Date page mapping:
  - Stimulus: one page_btn pulse, then hold page_btn high for 100 cycles.
  - Required: page = 1 one cycle after the edge, with no second toggle. Digits 3 and 2 show ~0x5B and ~0x3F. Digit 1 shows year_7seg[13:7] even when year_7seg[27:14] = all ones.
- Blink on edit:
  - Stimulus: set edit_field = 2 (min).
  - Required: page is forced to 0. Digits 4 and 3 show 0x7F for 400 cycles and the min pattern for the next 400 cycles. Other digits are unaffected.
- Forced page vs button:
  - Stimulus: edit_field = 5 with a simultaneous page_btn edge.
  - Required: page stays 1. After edit_field returns to 0, a further page_btn edge toggles page to 0.
- Mid-operation reset:
  - Stimulus: assert reset during digit 5.
  - Required: an = FF in the same cycle. After release, the scan restarts at digit 1 after 16 cycles.
